// File: rtl/seg_scan_arbiter_if.sv
// Requester-side handshake bundle for the shared seven-segment display.
// The requester (master) offers a frame; the arbiter (slave) returns a combinational ready.
interface seg_scan_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic [7:0]  req0_mask;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic [7:0]  req1_mask;
    logic        req1_ready;

    modport master (
        output req0_valid, req0_data, req0_mask,
        output req1_valid, req1_data, req1_mask,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_mask,
        input  req1_valid, req1_data, req1_mask,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/seg_scan_arbiter.sv
// Purpose: round-robin share of an 8-digit 7-seg display, frame-boundary swaps, multiplexed scan.
// Latency: ready is combinational; first digit reaches the pins 1 cycle after the accept edge.
// Backpressure: ready only in IDLE or the last dwell cycle of a frame; requesters hold payload until then.
module seg_scan_arbiter #(
    parameter int CLK_DIV  = 1000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_arbiter_if.slave  req,
    output logic [7:0]         o_seg,
    output logic [7:0]         o_digit_sel,
    output logic               o_owner
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   data, data_nxt;
    logic [7:0]    mask, mask_nxt;
    logic          owner, owner_nxt;
    logic          last, last_nxt;

    logic          frame_end;
    logic          window;
    logic          grant0, grant1;
    logic          acc0, acc1;

    logic [7:0]    vis;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic [7:0]    seg_nxt, sel_nxt;

    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 8'hFC;
            4'h1: enc = 8'h60;
            4'h2: enc = 8'hDA;
            4'h3: enc = 8'hF2;
            4'h4: enc = 8'h66;
            4'h5: enc = 8'hB6;
            4'h6: enc = 8'hBE;
            4'h7: enc = 8'hE0;
            4'h8: enc = 8'hFE;
            4'h9: enc = 8'hE6;
            4'hA: enc = 8'hEE;
            4'hB: enc = 8'h3E;
            4'hC: enc = 8'h9C;
            4'hD: enc = 8'h7A;
            4'hE: enc = 8'h9E;
            default: enc = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
            mask  <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            data  <= data_nxt;
            mask  <= mask_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        data_nxt  = data;
        mask_nxt  = mask;
        owner_nxt = owner;
        last_nxt  = last;

        frame_end = (state == SHOW) && (cnt == CNT_LAST) && (idx == 3'd7);
        window    = (state == IDLE) || frame_end;

        // On contention the requester that did not win last time gets the slot.
        grant0 = req.req0_valid && (!req.req1_valid || last);
        grant1 = req.req1_valid && (!req.req0_valid || !last);
        acc0   = window && grant0;
        acc1   = window && grant1;
        req.req0_ready = acc0;
        req.req1_ready = acc1;

        if (state == SHOW) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                idx_nxt = idx + 3'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        if (acc0 || acc1) begin
            data_nxt  = acc1 ? req.req1_data : req.req0_data;
            mask_nxt  = acc1 ? req.req1_mask : req.req0_mask;
            owner_nxt = acc1;
            last_nxt  = acc1;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = (mask_nxt == 8'h00) ? IDLE : SHOW;
        end
    end

    always_comb begin
        vis   = '0;
        upper = '0;
        for (int k = 0; k < 8; k++) begin
            upper  = data >> (4 * k);
            vis[k] = mask[k] && !(LZ_BLANK && (k > 0) && (upper == 32'd0));
        end
        nib     = data[{idx, 2'b00} +: 4];
        seg_nxt = 8'hFF;
        sel_nxt = 8'hFF;
        if ((state == SHOW) && vis[idx]) begin
            sel_nxt = ~(8'b1 << idx);
            seg_nxt = ~enc(nib);
        end
    end

    // Pins blank asynchronously on reset so a mid-frame reset never leaves a digit lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_seg       <= 8'hFF;
            o_digit_sel <= 8'hFF;
        end else begin
            o_seg       <= seg_nxt;
            o_digit_sel <= sel_nxt;
        end
    end

    assign o_owner = owner;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter with CLK_DIV=4 and leading-zero blanking enabled.
module tb_seg_scan_arbiter;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] o_seg, o_digit_sel;
    logic       o_owner;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan_arbiter_if bus ();

    seg_scan_arbiter #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .o_seg       (o_seg),
        .o_digit_sel (o_digit_sel),
        .o_owner     (o_owner)
    );

    function automatic logic [7:0] enc_ref(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
              8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        return t[n];
    endfunction

    // Expected pin values for one full frame, one entry per clock.
    function automatic void push_frame(input logic [31:0] d, input logic [7:0] m);
        logic [31:0] up;
        logic        v;
        logic [7:0]  sel, seg;
        for (int k = 0; k < 8; k++) begin
            up  = d >> (4 * k);
            v   = m[k] && !((k > 0) && (up == 32'd0));
            sel = v ? ~(8'b1 << k) : 8'hFF;
            seg = v ? ~enc_ref(up[3:0]) : 8'hFF;
            for (int r = 0; r < CLK_DIV; r++) exp_q.push_back({sel, seg});
        end
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_mask = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_mask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h want=ff", o_seg); end
        checks++; if (o_digit_sel !== 8'hFF) begin failures++; $display("FAIL reset_sel got=%h want=ff", o_digit_sel); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", {bus.req0_ready, bus.req1_ready}); end
        checks++; if (o_owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b want=0", o_owner); end
        rst = 1'b1;
    endtask

    task automatic test_basic_scan();
        logic [15:0] e;
        do_reset();
        bus.req0_data = 32'h0000_00A5; bus.req0_mask = 8'hFF; bus.req0_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL basic_ready got=%b want=10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        exp_q.push_back(16'hFFFF);
        repeat (2) begin
            repeat (4)  exp_q.push_back({8'hFE, 8'h49});
            repeat (4)  exp_q.push_back({8'hFD, 8'h11});
            repeat (24) exp_q.push_back(16'hFFFF);
        end
        for (int c = 0; c <= 64; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL basic_scan underflow c=%0d", c); end
            else begin
                e = exp_q.pop_front();
                if ({o_digit_sel, o_seg} !== e) begin failures++; $display("FAIL basic_scan c=%0d got sel/seg=%h/%h want %h/%h", c, o_digit_sel, o_seg, e[15:8], e[7:0]); end
            end
        end
        checks++; if (o_owner !== 1'b0) begin failures++; $display("FAIL basic_owner got=%b want=0", o_owner); end
    endtask

    task automatic test_contention();
        logic [15:0] e;
        do_reset();
        bus.req0_data = 32'h1234_5678; bus.req0_mask = 8'hFF; bus.req0_valid = 1'b1;
        bus.req1_data = 32'h0ABC_DEF0; bus.req1_mask = 8'h7E; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL contend_first got=%b want=10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        exp_q.push_back(16'hFFFF);
        push_frame(32'h1234_5678, 8'hFF);
        for (int c = 0; c <= 72; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL contend_scan underflow c=%0d", c); end
            else begin
                e = exp_q.pop_front();
                if ({o_digit_sel, o_seg} !== e) begin failures++; $display("FAIL contend_scan c=%0d got sel/seg=%h/%h want %h/%h", c, o_digit_sel, o_seg, e[15:8], e[7:0]); end
            end
            if (c == 32) begin
                checks++; if (o_owner !== 1'b1) begin failures++; $display("FAIL contend_owner1 got=%b want=1", o_owner); end
                bus.req1_valid = 1'b0;
                push_frame(32'h0ABC_DEF0, 8'h7E);
            end
            if (c == 40) begin
                bus.req0_data = 32'h0000_00F1; bus.req0_mask = 8'h03; bus.req0_valid = 1'b1;
                bus.req1_valid = 1'b1;
            end
            if (c == 64) begin
                checks++; if (o_owner !== 1'b0) begin failures++; $display("FAIL contend_owner0 got=%b want=0", o_owner); end
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                push_frame(32'h0000_00F1, 8'h03);
            end
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== {c == 63, c == 31}) begin
                failures++; $display("FAIL contend_ready c=%0d got=%b want=%b", c, {bus.req0_ready, bus.req1_ready}, {c == 63, c == 31});
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mid_frame();
        logic [15:0] e;
        do_reset();
        bus.req0_data = 32'h9000_0003; bus.req0_mask = 8'h81; bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b want=1", bus.req0_ready); end
        @(posedge clk); #1;
        // Payload changes after the handshake must not reach the display.
        bus.req0_valid = 1'b0; bus.req0_data = 32'hFFFF_FFFF;
        exp_q.push_back(16'hFFFF);
        push_frame(32'h9000_0003, 8'h81);
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL mid_scan underflow c=%0d", c); end
            else begin
                e = exp_q.pop_front();
                if ({o_digit_sel, o_seg} !== e) begin failures++; $display("FAIL mid_scan c=%0d got sel/seg=%h/%h want %h/%h", c, o_digit_sel, o_seg, e[15:8], e[7:0]); end
            end
            if (c == 12) begin
                bus.req1_data = 32'h0000_0042; bus.req1_mask = 8'h01; bus.req1_valid = 1'b1;
            end
            if (c == 32) begin
                checks++; if (o_owner !== 1'b1) begin failures++; $display("FAIL mid_owner got=%b want=1", o_owner); end
                bus.req1_valid = 1'b0;
            end
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== {1'b0, c == 31}) begin
                failures++; $display("FAIL mid_ready c=%0d got=%b want=%b", c, {bus.req0_ready, bus.req1_ready}, {1'b0, c == 31});
            end
        end
        exp_q.delete();
    endtask

    task automatic test_clear_mask();
        logic [15:0] e;
        do_reset();
        bus.req0_data = 32'h8765_4321; bus.req0_mask = 8'hFF; bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        bus.req0_data = 32'h0; bus.req0_mask = 8'h00;
        exp_q.push_back(16'hFFFF);
        push_frame(32'h8765_4321, 8'hFF);
        for (int c = 0; c <= 35; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL clear_scan underflow c=%0d", c); end
            else begin
                e = exp_q.pop_front();
                if ({o_digit_sel, o_seg} !== e) begin failures++; $display("FAIL clear_scan c=%0d got sel/seg=%h/%h want %h/%h", c, o_digit_sel, o_seg, e[15:8], e[7:0]); end
            end
            if (c == 32) begin
                bus.req0_valid = 1'b0;
                exp_q.push_back(16'hFFFF);
                exp_q.push_back(16'hFFFF);
            end
            if (c == 33) begin
                bus.req1_data = 32'h0000_0005; bus.req1_mask = 8'h01; bus.req1_valid = 1'b1;
            end
            if (c == 34) begin
                checks++; if (o_owner !== 1'b1) begin failures++; $display("FAIL clear_owner got=%b want=1", o_owner); end
                bus.req1_valid = 1'b0;
                exp_q.push_back({8'hFE, 8'h49});
            end
            #1;
            if (c <= 32) begin
                checks++;
                if (bus.req0_ready !== (c == 31)) begin failures++; $display("FAIL clear_ready0 c=%0d got=%b want=%b", c, bus.req0_ready, c == 31); end
            end
            if (c == 33) begin
                checks++;
                if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL clear_idle_ready1 got=%b want=1", bus.req1_ready); end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req0_data = 32'h0000_0088; bus.req0_mask = 8'hFF; bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({o_digit_sel, o_seg} !== {8'hFE, ~enc_ref(4'h8)}) begin failures++; $display("FAIL areset_pre got=%h/%h want fe/%h", o_digit_sel, o_seg, ~enc_ref(4'h8)); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({o_digit_sel, o_seg} !== 16'hFFFF) begin failures++; $display("FAIL areset_async got=%h/%h want ff/ff", o_digit_sel, o_seg); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_digit_sel, o_seg, o_owner, bus.req0_ready, bus.req1_ready} !== {16'hFFFF, 3'b000}) begin
                failures++; $display("FAIL areset_blank c=%0d got sel/seg=%h/%h owner=%b", c, o_digit_sel, o_seg, o_owner);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_scan();
        test_contention();
        test_mid_frame();
        test_clear_mask();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
